fifo_broadcast: RTL and testbench
=================================

FIFO_BROADCAST -- requirements
Module: fifo_broadcast

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width in bits.
REQ-002 SHALL have parameter LOG2_DEPTH, default 5, meaning storage depth DEPTH = 2**LOG2_DEPTH words.
REQ-003 SHALL have parameter NUM_WRITE_CHANNELS, default 2, meaning number of write requesters (NW >= 1).
REQ-004 SHALL have parameter NUM_READ_CHANNELS, default 3, meaning number of independent readers (NR >= 1).
REQ-005 SHALL have parameter ALMOSTFULL_SLACK, default 4, meaning free-slot threshold for almostfull.
REQ-006 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-008 SHALL have port wr_valid  input  NW  per-channel write request.
REQ-009 SHALL have port wr_data  input  NW*WIDTH  per-channel write data; channel k at bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port wr_ready  output  NW  per-channel grant; write accepted when wr_valid[k] && wr_ready[k].
REQ-011 SHALL have port almostfull  output  1  occupancy of slowest reader >= DEPTH-ALMOSTFULL_SLACK.
REQ-012 SHALL have port count  output  LOG2_DEPTH+1  maximum occupancy over all readers.
REQ-013 SHALL have port rd_re  input  NR  per-reader read enable.
REQ-014 SHALL have port rd_empty  output  NR  per-reader empty.
REQ-015 SHALL have port rd_rvalid  output  NR  per-reader read data valid.
REQ-016 SHALL have port rd_rdata  output  NR*WIDTH  per-reader read data; reader j at [j*WIDTH +: WIDTH].
REQ-017 SHALL have port err  output  1  sticky read-underflow flag (see Configuration).

Function
REQ-018 SHALL hold one shared storage array of DEPTH words, one write pointer and NR independent read pointers, each LOG2_DEPTH+1 bits, wrapping modulo 2*DEPTH.
REQ-019 SHALL compute occupancy of reader j as wptr - rptr[j] (modulo 2*DEPTH); count = max over j; full = (count == DEPTH).
REQ-020 SHALL round-robin arbitrate: priority pointer p; grant the first k with wr_valid[k] searching p, p+1, ... mod NW; at most one wr_ready bit high per cycle.
REQ-021 SHALL drive wr_ready all-zero while full; wr_ready is combinational from wr_valid, p and full.
REQ-022 SHALL, on accepted write from channel k, store wr_data[k] at wptr, increment wptr and set p = (k+1) mod NW at the same edge; with no accept p holds.
REQ-023 SHALL make every accepted word visible to all NR readers; rd_empty[j] deasserts the cycle after the accepting edge.
REQ-024 SHALL, on rd_re[j] && !rd_empty[j], register storage[rptr[j]] into rd_rdata[j], assert rd_rvalid[j] the next cycle (latency 1) and increment rptr[j].
REQ-025 SHALL ignore rd_re[j] while rd_empty[j]; rd_rvalid[j] = 0 next cycle and rptr[j], rd_rdata[j] unchanged.
REQ-026 SHALL not bypass: a read by the slowest reader in a full cycle does not enable a write in that same cycle.
REQ-027 SHALL allow a simultaneous write and reads in one cycle when not full; readers at other pointers unaffected.
REQ-028 SHALL deassert rd_rvalid[j] in any cycle not preceded by a valid read of reader j.

Reset
REQ-029 SHALL, while reset = 0, asynchronously clear wptr, all rptr, p, rd_rvalid, rd_rdata and err to 0; storage contents unspecified.
REQ-030 SHALL, on reset mid-operation, discard all stored words: after release rd_empty = all-ones, count = 0, almostfull = 0, wr_ready granted from channel 0 priority.

Configuration
REQ-031 SHALL, with macro FIFO_BROADCAST_UNDERFLOW_ERR_EN defined, set err sticky high one cycle after any rd_re[j] && rd_empty[j], cleared only by reset.
REQ-032 SHALL, without FIFO_BROADCAST_UNDERFLOW_ERR_EN, tie err to 0 and contain no underflow logic.

Verification
REQ-033 SHALL cover: NW=2, wr_valid=2'b11 for 4 cycles, data ch0=0xA0.., ch1=0xB0.. -> accept order ch0,ch1,ch0,ch1; every reader reads 0xA0,0xB0,0xA1,0xB1.
REQ-034 SHALL cover: DEPTH=32, 32 writes, no reads -> count=32, wr_ready=0, almostfull=1 from count 28; reader 0 reads one -> count stays 32 (readers 1,2 full).
REQ-035 SHALL cover: all readers drain except reader 2 lagging by 5 -> count=5, rd_empty=3'b011, reader 2 gets correct remaining words.
REQ-036 SHALL cover: rd_re[1]=1 while empty -> rd_rvalid[1]=0 next cycle, err=1 with macro, err=0 without.
REQ-037 SHALL cover: pointer wrap, 100 words through with reads interleaved -> data order preserved, no loss or duplication at wrap.
REQ-038 SHALL cover: reset asserted with 10 words stored -> immediately rd_rvalid=0; after release rd_empty=all-ones, count=0.

Source files
------------

// File: rtl/fifo_broadcast.sv
// fifo_broadcast: one shared FIFO store, round-robin write arbitration across NW channels, NR independent readers.
// Define FIFO_BROADCAST_UNDERFLOW_ERR_EN to enable the sticky read-underflow flag on err.
module fifo_broadcast #(
    parameter int WIDTH              = 8,
    parameter int LOG2_DEPTH         = 5,
    parameter int NUM_WRITE_CHANNELS = 2,
    parameter int NUM_READ_CHANNELS  = 3,
    parameter int ALMOSTFULL_SLACK   = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_WRITE_CHANNELS-1:0]         wr_valid,
    input  logic [NUM_WRITE_CHANNELS*WIDTH-1:0]   wr_data,
    output logic [NUM_WRITE_CHANNELS-1:0]         wr_ready,
    output logic                                  almostfull,
    output logic [LOG2_DEPTH:0]                   count,
    input  logic [NUM_READ_CHANNELS-1:0]          rd_re,
    output logic [NUM_READ_CHANNELS-1:0]          rd_empty,
    output logic [NUM_READ_CHANNELS-1:0]          rd_rvalid,
    output logic [NUM_READ_CHANNELS*WIDTH-1:0]    rd_rdata,
    output logic                                  err
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int PW    = LOG2_DEPTH + 1;
    localparam int NW    = NUM_WRITE_CHANNELS;
    localparam int NR    = NUM_READ_CHANNELS;
    localparam int PRW   = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [PW-1:0]  FULL_LEVEL = PW'(DEPTH);
    localparam logic [PW-1:0]  AF_LEVEL   = PW'(DEPTH - ALMOSTFULL_SLACK);
    localparam logic [PRW:0]   NW_EXT     = (PRW+1)'(NW);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PW-1:0]       wptr_q, wptr_d;
    logic [PW-1:0]       rptr_q [NR];
    logic [PW-1:0]       rptr_d [NR];
    logic [PRW-1:0]      prio_q, prio_d;
    logic [NR-1:0]       rvalid_q, rvalid_d;
    logic [NR*WIDTH-1:0] rdata_q, rdata_d;

    logic [PW-1:0]       occ [NR];
    logic [PW-1:0]       max_occ;
    logic [NR-1:0]       empty;
    logic [NR-1:0]       rd_fire;
    logic                full;
    logic [NW-1:0]       grant;
    logic [PRW-1:0]      grant_idx;
    logic [PRW:0]        arb_sum;
    logic                arb_found;
    logic                wr_fire;

    // Occupancy per reader is pointer distance; the slowest reader bounds the shared store.
    always_comb begin
        max_occ = '0;
        empty   = '0;
        for (int j = 0; j < NR; j++) begin
            occ[j]   = wptr_q - rptr_q[j];
            empty[j] = (occ[j] == '0);
            if (occ[j] > max_occ) max_occ = occ[j];
        end
    end

    assign full       = (max_occ == FULL_LEVEL);
    assign count      = max_occ;
    assign almostfull = (max_occ >= AF_LEVEL);
    assign rd_empty   = empty;

    // Round-robin search starting at prio_q; full blocks every grant regardless of same-cycle reads.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        grant     = '0;
        grant_idx = '0;
        arb_sum   = '0;
        arb_found = 1'b0;
        for (int i = 0; i < NW; i++) begin
            arb_sum = {1'b0, prio_q} + (PRW+1)'(i);
            if (arb_sum >= NW_EXT) arb_sum = arb_sum - NW_EXT;
            if (!arb_found && wr_valid[arb_sum[PRW-1:0]]) begin
                grant[arb_sum[PRW-1:0]] = 1'b1;
                grant_idx               = arb_sum[PRW-1:0];
                arb_found               = 1'b1;
            end
        end
        if (full) grant = '0;
    end

    assign wr_ready = grant;
    assign wr_fire  = |grant;

    always_comb begin
        wptr_d  = wptr_q;
        prio_d  = prio_q;
        rdata_d = rdata_q;
        if (wr_fire) begin
            wptr_d = wptr_q + 1'b1;
            prio_d = (grant_idx == PRW'(NW - 1)) ? '0 : grant_idx + 1'b1;
        end
        for (int j = 0; j < NR; j++) begin
            rd_fire[j] = rd_re[j] & ~empty[j];
            rptr_d[j]  = rptr_q[j];
            if (rd_fire[j]) begin
                rdata_d[j*WIDTH +: WIDTH] = mem_q[rptr_q[j][LOG2_DEPTH-1:0]];
                rptr_d[j]                 = rptr_q[j] + 1'b1;
            end
        end
        rvalid_d = rd_fire;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q   <= '0;
            prio_q   <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            for (int j = 0; j < NR; j++) rptr_q[j] <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
            wptr_q   <= wptr_d;
            prio_q   <= prio_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            for (int j = 0; j < NR; j++) rptr_q[j] <= rptr_d[j];
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers alone define which words are live.
    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wptr_q[LOG2_DEPTH-1:0]] <= wr_data[grant_idx*WIDTH +: WIDTH];
    end

    assign rd_rvalid = rvalid_q;
    assign rd_rdata  = rdata_q;

`ifdef FIFO_BROADCAST_UNDERFLOW_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_q | (|(rd_re & empty));
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_broadcast.sv
// Self-checking bench for fifo_broadcast: vector table, directed corner sequences and
// randomized traffic checked against a queue-style reference model.
module tb_fifo_broadcast;
    localparam int W  = 8;
    localparam int LD = 5;
    localparam int D  = 1 << LD;
    localparam int NW = 2;
    localparam int NR = 3;
    localparam int SL = 4;

    logic              clk;
    logic              reset;
    logic [NW-1:0]     wr_valid;
    logic [NW*W-1:0]   wr_data;
    logic [NW-1:0]     wr_ready;
    logic              almostfull;
    logic [LD:0]       count;
    logic [NR-1:0]     rd_re;
    logic [NR-1:0]     rd_empty;
    logic [NR-1:0]     rd_rvalid;
    logic [NR*W-1:0]   rd_rdata;
    logic              err;

    fifo_broadcast #(
        .WIDTH(W), .LOG2_DEPTH(LD), .NUM_WRITE_CHANNELS(NW),
        .NUM_READ_CHANNELS(NR), .ALMOSTFULL_SLACK(SL)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .almostfull(almostfull), .count(count),
        .rd_re(rd_re), .rd_empty(rd_empty), .rd_rvalid(rd_rvalid),
        .rd_rdata(rd_rdata), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: every accepted word is appended to hist; reader j has consumed rd_total[j] words.
    logic [W-1:0] hist [0:4095];
    int           wr_total;
    int           rd_total [NR];
    int           p;
    logic [W-1:0] exp_rdata [NR];
    bit           exp_err;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        wr_total = 0;
        p        = 0;
        exp_err  = 1'b0;
        for (int j = 0; j < NR; j++) begin
            rd_total[j]  = 0;
            exp_rdata[j] = '0;
        end
    endtask

    function automatic int model_count();
        int mx = 0;
        for (int j = 0; j < NR; j++)
            if (wr_total - rd_total[j] > mx) mx = wr_total - rd_total[j];
        return mx;
    endfunction

    // One clock of stimulus; combinational outputs checked before the edge, registered ones #1 after.
    task automatic cycle(input logic [NW-1:0] wv, input logic [NW*W-1:0] wd,
                         input logic [NR-1:0] re, output logic [NW-1:0] got_ready);
        logic [NW-1:0]   er;
        logic [NR-1:0]   eempty;
        logic [NR-1:0]   fire;
        logic [NR*W-1:0] packed_rd;
        int              mx;
        int              k;
        wr_valid = wv;
        wr_data  = wd;
        rd_re    = re;
        #1;
        mx = model_count();
        for (int j = 0; j < NR; j++) eempty[j] = (wr_total == rd_total[j]);
        er = '0;
        if (mx != D) begin
            for (int i = 0; i < NW; i++) begin
                k = (p + i) % NW;
                if (er == '0 && wv[k]) er[k] = 1'b1;
            end
        end
        check("wr_ready", {62'b0, wr_ready}, {62'b0, er});
        check("count", {58'b0, count}, 64'(mx));
        check("almostfull", {63'b0, almostfull}, {63'b0, (mx >= D - SL)});
        check("rd_empty", {61'b0, rd_empty}, {61'b0, eempty});
        got_ready = wr_ready;
        fire = re & ~eempty;
        if ((re & eempty) != '0) exp_err = 1'b1;
        @(posedge clk);
        #1;
        for (int j = 0; j < NR; j++) begin
            if (fire[j]) begin
                exp_rdata[j] = hist[rd_total[j] % 4096];
                rd_total[j]++;
            end
        end
        for (int i = 0; i < NW; i++) begin
            if (er[i]) begin
                hist[wr_total % 4096] = wd[i*W +: W];
                wr_total++;
                p = (i + 1) % NW;
            end
        end
        for (int j = 0; j < NR; j++) packed_rd[j*W +: W] = exp_rdata[j];
        check("rd_rvalid", {61'b0, rd_rvalid}, {61'b0, fire});
        check("rd_rdata", {40'b0, rd_rdata}, {40'b0, packed_rd});
`ifdef FIFO_BROADCAST_UNDERFLOW_ERR_EN
        check("err", {63'b0, err}, {63'b0, exp_err});
`else
        check("err", {63'b0, err}, 64'b0);
`endif
    endtask

    task automatic do_reset();
        wr_valid = '0;
        wr_data  = '0;
        rd_re    = '0;
        reset    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [NW-1:0]   wv;
        logic [NW*W-1:0] wd;
        logic [NR-1:0]   re;
        logic [NW-1:0]   exp_ready;
        logic [NR-1:0]   exp_rvalid;
        logic [W-1:0]    exp_rdata;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NW-1:0] got;
        logic [W-1:0]  wd0, wd1;

        // Both channels request for 4 cycles; unaccepted data is held until granted.
        vecs[0] = '{2'b11, {8'hB0, 8'hA0}, 3'b000, 2'b01, 3'b000, 8'h00};
        vecs[1] = '{2'b11, {8'hB0, 8'hA1}, 3'b000, 2'b10, 3'b000, 8'h00};
        vecs[2] = '{2'b11, {8'hB1, 8'hA1}, 3'b000, 2'b01, 3'b000, 8'h00};
        vecs[3] = '{2'b11, {8'hB1, 8'hA2}, 3'b000, 2'b10, 3'b000, 8'h00};
        vecs[4] = '{2'b00, 16'h0000,       3'b111, 2'b00, 3'b111, 8'hA0};
        vecs[5] = '{2'b00, 16'h0000,       3'b111, 2'b00, 3'b111, 8'hB0};
        vecs[6] = '{2'b00, 16'h0000,       3'b111, 2'b00, 3'b111, 8'hA1};
        vecs[7] = '{2'b00, 16'h0000,       3'b111, 2'b00, 3'b111, 8'hB1};
        vecs[8] = '{2'b00, 16'h0000,       3'b010, 2'b00, 3'b000, 8'h00};
        vecs[9] = '{2'b10, {8'hC0, 8'h00}, 3'b000, 2'b10, 3'b000, 8'h00};

        do_reset();
        check("reset_rvalid", {61'b0, rd_rvalid}, 64'b0);
        check("reset_empty", {61'b0, rd_empty}, 64'b111);
        check("reset_count", {58'b0, count}, 64'b0);

        for (int v = 0; v < 10; v++) begin
            cycle(vecs[v].wv, vecs[v].wd, vecs[v].re, got);
            check("vec_ready", {62'b0, got}, {62'b0, vecs[v].exp_ready});
            check("vec_rvalid", {61'b0, rd_rvalid}, {61'b0, vecs[v].exp_rvalid});
            if (vecs[v].exp_rvalid != '0)
                check("vec_rdata", {40'b0, rd_rdata}, {40'b0, {3{vecs[v].exp_rdata}}});
            if (v == 8) begin
`ifdef FIFO_BROADCAST_UNDERFLOW_ERR_EN
                check("underflow_err", {63'b0, err}, 64'b1);
`else
                check("underflow_err", {63'b0, err}, 64'b0);
`endif
            end
        end

        // Fill to full with no reads, then a reader-0 read must neither free space nor admit a write.
        do_reset();
        for (int i = 0; i < D; i++) cycle(2'b01, {8'h00, 8'(8'h40 + i)}, 3'b000, got);
        #1;
        check("full_count", {58'b0, count}, 64'd32);
        check("full_almostfull", {63'b0, almostfull}, 64'b1);
        cycle(2'b11, {8'hEE, 8'hDD}, 3'b001, got);
        check("full_no_bypass", {62'b0, got}, 64'b0);
        check("full_after_r0", {58'b0, count}, 64'd32);

        // Readers 0 and 1 drain completely, reader 2 lags by 5.
        for (int i = 0; i < D; i++)
            cycle(2'b00, 16'h0, {(i < D - 5) ? 1'b1 : 1'b0, 1'b1, (i < D - 1) ? 1'b1 : 1'b0}, got);
        #1;
        check("lag_count", {58'b0, count}, 64'd5);
        check("lag_empty", {61'b0, rd_empty}, 64'b011);
        for (int i = 0; i < 5; i++) cycle(2'b00, 16'h0, 3'b100, got);
        #1;
        check("drained_empty", {61'b0, rd_empty}, 64'b111);

        // 100 words through the wrap point with all readers reading every cycle.
        for (int i = 0; i < 120; i++) begin
            wd0 = 8'($urandom);
            wd1 = 8'($urandom);
            cycle((i < 100) ? 2'(1 + $urandom_range(0, 2)) : 2'b00, {wd1, wd0},
                  (i > 0) ? 3'b111 : 3'b000, got);
        end
        #1;
        check("wrap_empty", {61'b0, rd_empty}, 64'b111);

        // Randomized traffic: a fill-biased phase then a drain-biased phase.
        for (int i = 0; i < 800; i++) begin
            logic [NR-1:0] re;
            for (int j = 0; j < NR; j++)
                re[j] = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            wd0 = 8'($urandom);
            wd1 = 8'($urandom);
            cycle(2'($urandom), {wd1, wd0}, re, got);
        end

        // Reset mid-operation with 10 words stored and read data valid.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(2'b10, {8'(8'h70 + i), 8'h00}, 3'b000, got);
        cycle(2'b00, 16'h0, 3'b111, got);
        check("pre_reset_rvalid", {61'b0, rd_rvalid}, 64'b111);
        reset = 1'b0;
        #1;
        check("async_rvalid", {61'b0, rd_rvalid}, 64'b0);
        check("async_rdata", {40'b0, rd_rdata}, 64'b0);
        check("async_count", {58'b0, count}, 64'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check("post_reset_empty", {61'b0, rd_empty}, 64'b111);
        check("post_reset_almostfull", {63'b0, almostfull}, 64'b0);
        cycle(2'b11, {8'h22, 8'h11}, 3'b000, got);
        check("post_reset_prio", {62'b0, got}, 64'b01);
        cycle(2'b00, 16'h0, 3'b111, got);
        check("post_reset_data", {40'b0, rd_rdata}, {40'b0, {3{8'h11}}});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
